// File: rtl/camera_capture_if.sv
// Byte-stream input and packed-word output bundle between the BT.656 decoder
// and camera_capture; master drives bytes, slave returns words and timing flags.
interface camera_capture_if;
    logic [7:0]  din;
    logic        din_valid;
    logic [31:0] data_out;
    logic        pixel_done;
    logic        frame_done;
    logic        field;
    logic [9:0]  line_count;

    modport master (
        output din,
        output din_valid,
        input  data_out,
        input  pixel_done,
        input  frame_done,
        input  field,
        input  line_count
    );

    modport slave (
        input  din,
        input  din_valid,
        output data_out,
        output pixel_done,
        output frame_done,
        output field,
        output line_count
    );
endinterface

// File: rtl/camera_capture.sv
// BT.656 front end: locks onto SAV/EAV codes, packs active video into
// {Cb,Y0,Cr,Y1} words and reports line/frame progress.
module camera_capture #(
    parameter int PAIRS_PER_LINE = 360,
    parameter bit CHECK_PROT     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    camera_capture_if.slave   bus
);

    localparam int PW = $clog2(PAIRS_PER_LINE + 1);
    localparam logic [PW-1:0] PAIR_MAX = PW'(PAIRS_PER_LINE);

    typedef enum logic [2:0] {
        SEARCH,
        SYNC1,
        SYNC2,
        XY,
        ACTIVE,
        BLANK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [PW-1:0] pair_cnt_q, pair_cnt_d;
    logic [23:0]   pack_q, pack_d;
    logic [31:0]   data_out_q, data_out_d;
    logic          pixel_done_q, pixel_done_d;
    logic          frame_done_q, frame_done_d;
    logic          field_q, field_d;
    logic [9:0]    line_count_q, line_count_d;
    logic          prev_v_q, prev_v_d;
    logic          from_active_q, from_active_d;

    logic       code_f, code_v, code_h;
    logic [3:0] exp_prot;
    logic       code_ok;

    assign code_f   = bus.din[6];
    assign code_v   = bus.din[5];
    assign code_h   = bus.din[4];
    assign exp_prot = {code_v ^ code_h, code_f ^ code_h, code_f ^ code_v, code_f ^ code_v ^ code_h};
    assign code_ok  = bus.din[7] && (!CHECK_PROT || (bus.din[3:0] == exp_prot));

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        pair_cnt_d    = pair_cnt_q;
        pack_d        = pack_q;
        data_out_d    = data_out_q;
        pixel_done_d  = 1'b0;
        frame_done_d  = 1'b0;
        field_d       = field_q;
        line_count_d  = line_count_q;
        prev_v_d      = prev_v_q;
        from_active_d = from_active_q;

        if (bus.din_valid) begin
            case (state_q)
                SEARCH, BLANK: begin
                    if (bus.din == 8'hFF) begin
                        state_d       = SYNC1;
                        from_active_d = 1'b0;
                    end
                end
                SYNC1: state_d = (bus.din == 8'h00) ? SYNC2 : SEARCH;
                SYNC2: state_d = (bus.din == 8'h00) ? XY : SEARCH;
                XY: begin
                    if (!code_ok) begin
                        state_d = SEARCH;
                    end else begin
                        field_d  = code_f;
                        prev_v_d = code_v;
                        if (!code_h && !code_v) begin
                            state_d    = ACTIVE;
                            byte_idx_d = 2'd0;
                            pair_cnt_d = '0;
                        end else begin
                            state_d = BLANK;
                        end
                        if (code_h && from_active_q && (line_count_q != 10'd1023)) begin
                            line_count_d = line_count_q + 10'd1;
                        end
                        // End of a frame's active video: the clear overrides the EAV increment.
                        if (code_v && !prev_v_q && code_f) begin
                            frame_done_d = 1'b1;
                            line_count_d = 10'd0;
                        end
                    end
                end
                ACTIVE: begin
                    if (bus.din == 8'hFF) begin
                        state_d       = SYNC1;
                        from_active_d = 1'b1;
                        byte_idx_d    = 2'd0;
                    end else if (pair_cnt_q < PAIR_MAX) begin
                        pack_d     = {pack_q[15:0], bus.din};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            data_out_d   = {pack_q, bus.din};
                            pixel_done_d = 1'b1;
                            pair_cnt_d   = pair_cnt_q + PW'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SEARCH;
            byte_idx_q    <= 2'd0;
            pair_cnt_q    <= '0;
            pack_q        <= 24'd0;
            data_out_q    <= 32'd0;
            pixel_done_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            field_q       <= 1'b0;
            line_count_q  <= 10'd0;
            prev_v_q      <= 1'b0;
            from_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            pair_cnt_q    <= pair_cnt_d;
            pack_q        <= pack_d;
            data_out_q    <= data_out_d;
            pixel_done_q  <= pixel_done_d;
            frame_done_q  <= frame_done_d;
            field_q       <= field_d;
            line_count_q  <= line_count_d;
            prev_v_q      <= prev_v_d;
            from_active_q <= from_active_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.pixel_done = pixel_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.field      = field_q;
    assign bus.line_count = line_count_q;

endmodule

// File: tb/tb_camera_capture.sv
// Drives one BT.656 byte stream into two captures (default and 2-pair line limit)
// and compares both against a byte-level model every cycle.
module tb_camera_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       cmp_en;

    int n_checks;
    int n_pass;

    camera_capture_if bus_a ();
    camera_capture_if bus_b ();

    assign bus_a.din       = din;
    assign bus_a.din_valid = din_valid;
    assign bus_b.din       = din;
    assign bus_b.din_valid = din_valid;

    camera_capture dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    camera_capture #(.PAIRS_PER_LINE(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Model state, index 0 = default DUT, index 1 = 2-pair DUT.
    int          m_limit [2] = '{360, 2};
    int          m_sync  [2];
    bit          m_vid   [2];
    bit          m_from  [2];
    bit          m_prev_v[2];
    bit          m_field [2];
    int          m_nb    [2];
    int          m_pairs [2];
    int          m_lc    [2];
    logic [31:0] m_acc   [2];
    logic [31:0] m_dout  [2];
    bit          m_pd    [2];
    bit          m_fd    [2];

    task automatic model_byte(input int k, input logic [7:0] b);
        bit f, v, h;
        logic [3:0] p;
        f = b[6];
        v = b[5];
        h = b[4];
        p = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        if (m_sync[k] == 3) begin
            m_sync[k] = 0;
            if (!b[7] || (b[3:0] != p)) begin
                m_vid[k] = 0;
            end else begin
                m_field[k] = f;
                m_fd[k]    = v && !m_prev_v[k] && f;
                m_prev_v[k] = v;
                m_vid[k]   = !h && !v;
                m_nb[k]    = 0;
                m_acc[k]   = 0;
                if (m_vid[k]) m_pairs[k] = 0;
                if (h && m_from[k] && m_lc[k] < 1023) m_lc[k]++;
                if (m_fd[k]) m_lc[k] = 0;
            end
        end else if (m_sync[k] != 0) begin
            if (b == 8'h00) m_sync[k]++;
            else begin
                m_sync[k] = 0;
                m_vid[k]  = 0;
            end
        end else if (b == 8'hFF) begin
            m_from[k] = m_vid[k];
            m_vid[k]  = 0;
            m_sync[k] = 1;
            m_nb[k]   = 0;
            m_acc[k]  = 0;
        end else if (m_vid[k] && m_pairs[k] < m_limit[k]) begin
            m_acc[k] = m_acc[k] | (32'(b) << (8 * (3 - m_nb[k])));
            m_nb[k]++;
            if (m_nb[k] == 4) begin
                m_dout[k] = m_acc[k];
                m_pd[k]   = 1;
                m_pairs[k]++;
                m_nb[k]   = 0;
                m_acc[k]  = 0;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_sync[k] = 0;   m_vid[k] = 0;    m_from[k] = 0;
                m_prev_v[k] = 0; m_field[k] = 0;  m_nb[k] = 0;
                m_pairs[k] = 0;  m_lc[k] = 0;     m_acc[k] = 0;
                m_dout[k] = 0;   m_pd[k] = 0;     m_fd[k] = 0;
            end else begin
                m_pd[k] = 0;
                m_fd[k] = 0;
                if (din_valid) model_byte(k, din);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_dut(input int k, input logic [31:0] dout, input logic pd,
                               input logic fd, input logic fld, input logic [9:0] lc);
        string t;
        t = (k == 0) ? "a" : "b";
        check_output({t, ".data_out"},   dout,      m_dout[k]);
        check_output({t, ".pixel_done"}, 32'(pd),   32'(m_pd[k]));
        check_output({t, ".frame_done"}, 32'(fd),   32'(m_fd[k]));
        check_output({t, ".field"},      32'(fld),  32'(m_field[k]));
        check_output({t, ".line_count"}, 32'(lc),   32'(m_lc[k]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            compare_dut(0, bus_a.data_out, bus_a.pixel_done, bus_a.frame_done, bus_a.field, bus_a.line_count);
            compare_dut(1, bus_b.data_out, bus_b.pixel_done, bus_b.frame_done, bus_b.field, bus_b.line_count);
        end
    end

    logic [31:0] words_a[$];
    logic [31:0] words_b[$];
    int          fd_a;

    always @(negedge clk) begin
        if (bus_a.pixel_done) words_a.push_back(bus_a.data_out);
        if (bus_b.pixel_done) words_b.push_back(bus_b.data_out);
        if (bus_a.frame_done) fd_a++;
    end

    task automatic clear_logs();
        words_a.delete();
        words_b.delete();
        fd_a = 0;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_code(input logic [7:0] xy, input int gap);
        apply_stimulus(8'hFF, gap);
        apply_stimulus(8'h00, gap);
        apply_stimulus(8'h00, gap);
        apply_stimulus(xy, gap);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        din       = 8'h00;
        din_valid = 1'b0;
        reset     = 1'b1;
        cmp_en    = 1'b0;
        n_checks  = 0;
        n_pass    = 0;
        fd_a      = 0;
        #2 reset = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst.data_out", bus_a.data_out, 32'h0);
        check_output("rst.line_count", 32'(bus_a.line_count), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Line capture with idle gaps between bytes
        clear_logs();
        send_code(8'h80, 1);
        for (int i = 1; i <= 8; i++) apply_stimulus(8'(i * 16), 1);
        send_code(8'h9D, 1);
        settle();
        check_output("line.nwords", 32'(words_a.size()), 32'd2);
        check_output("line.word0", words_a[0], 32'h10203040);
        check_output("line.word1", words_a[1], 32'h50607080);
        check_output("line.count", 32'(bus_a.line_count), 32'd1);

        // Bad protection: field held at 1 by a valid F=1 EAV first
        send_code(8'hDA, 0);
        clear_logs();
        send_code(8'h81, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(8'h55, 0);
        settle();
        check_output("prot.nwords", 32'(words_a.size()), 32'd0);
        check_output("prot.field", 32'(bus_a.field), 32'd1);
        check_output("prot.count", 32'(bus_a.line_count), 32'd1);

        // Frame end after three F=1 lines
        for (int l = 0; l < 3; l++) begin
            send_code(8'hC7, 0);
            for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h20 + i), 0);
            send_code(8'hDA, 0);
        end
        settle();
        check_output("frame.pre_count", 32'(bus_a.line_count), 32'd4);
        clear_logs();
        send_code(8'hF1, 0);
        settle();
        check_output("frame.pulses", 32'(fd_a), 32'd1);
        check_output("frame.count", 32'(bus_a.line_count), 32'd0);

        // Sync interrupt drops partial word, EAV still counts the line
        clear_logs();
        send_code(8'h80, 0);
        apply_stimulus(8'h11, 0);
        apply_stimulus(8'h22, 0);
        send_code(8'h9D, 0);
        settle();
        check_output("intr.nwords", 32'(words_a.size()), 32'd0);
        check_output("intr.count", 32'(bus_a.line_count), 32'd1);
        check_output("intr.field", 32'(bus_a.field), 32'd0);

        // Line overflow: 16 bytes, 2-pair DUT keeps only two words
        clear_logs();
        send_code(8'h80, 0);
        for (int i = 1; i <= 16; i++) apply_stimulus(8'(i), 0);
        send_code(8'h9D, 0);
        settle();
        check_output("ovf.a_nwords", 32'(words_a.size()), 32'd4);
        check_output("ovf.b_nwords", 32'(words_b.size()), 32'd2);
        check_output("ovf.b_word1", words_b[1], 32'h05060708);
        check_output("ovf.a_word3", words_a[3], 32'h0D0E0F10);

        // Reset mid-line, then a clean line
        send_code(8'h80, 0);
        apply_stimulus(8'hAA, 0);
        apply_stimulus(8'hBB, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("mrst.data_out", bus_a.data_out, 32'h0);
        check_output("mrst.count", 32'(bus_a.line_count), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        send_code(8'h80, 0);
        for (int i = 1; i <= 8; i++) apply_stimulus(8'(i * 16), 0);
        send_code(8'h9D, 0);
        settle();
        check_output("mrst.nwords", 32'(words_a.size()), 32'd2);
        check_output("mrst.word0", words_a[0], 32'h10203040);
        check_output("mrst.count1", 32'(bus_a.line_count), 32'd1);

        // Frame-ending EAV straight out of ACTIVE: clear beats increment
        clear_logs();
        send_code(8'hC7, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(8'h40, 0);
        send_code(8'hF1, 0);
        settle();
        check_output("coin.pulses", 32'(fd_a), 32'd1);
        check_output("coin.count", 32'(bus_a.line_count), 32'd0);

        // Saturation of line_count
        send_code(8'h80, 0);
        for (int l = 0; l < 1030; l++) begin
            send_code(8'h80, 0);
            send_code(8'h9D, 0);
        end
        settle();
        check_output("sat.a_count", 32'(bus_a.line_count), 32'd1023);
        check_output("sat.b_count", 32'(bus_b.line_count), 32'd1023);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
